// File: rtl/hazard_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : hazard_pkg
//  Description : Shared constants for the D-stage hazard controller:
//                forwarding-select codes, mult/div start classes,
//                the "never used" TUse value and scoreboard slot indices.
//  Revision    : 1.0 - initial release
// ============================================================================
package hazard_pkg;

    // Default width of TUse/TNew fields
    localparam int TN_W = 3;

    // D-stage operand source selects
    localparam logic [1:0] FWD_RF = 2'd0;
    localparam logic [1:0] FWD_E  = 2'd1;
    localparam logic [1:0] FWD_M  = 2'd2;
    localparam logic [1:0] FWD_W  = 2'd3;

    // Mult/div start class carried with an instruction
    localparam logic [1:0] MD_NONE = 2'b00;
    localparam logic [1:0] MD_MULT = 2'b01;
    localparam logic [1:0] MD_DIV  = 2'b10;

    // TUse value meaning "operand never read"
    localparam int TUSE_NEVER = 7;

    // Scoreboard slot indices, youngest first
    localparam int NSLOT  = 3;
    localparam int SLOT_E = 0;
    localparam int SLOT_M = 1;
    localparam int SLOT_W = 2;

endpackage
`default_nettype wire

// File: rtl/hazard_ctrl_md_busy_tracker.sv
`default_nettype none
// ============================================================================
//  Module      : md_busy_tracker
//  Description : Mult/div unit busy counter. The counter is loaded while a
//                mult/div start sits in the E slot, so the load becomes
//                visible the cycle after the start leaves E, then counts
//                down to zero.
//  Ports       : Clk, Reset    - clock, synchronous active-high reset
//                md_start_i    - MD start class of the instruction now in E
//                md_busy_o     - counter nonzero
//  Revision    : 1.0 - initial release
// ============================================================================
module md_busy_tracker #(
    parameter int MULT_CYC = 5,
    parameter int DIV_CYC  = 10
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic [1:0] md_start_i,
    output logic       md_busy_o
);
    import hazard_pkg::*;

    localparam int MAX_CYC = (DIV_CYC > MULT_CYC) ? DIV_CYC : MULT_CYC;
    localparam int CNT_W   = $clog2(MAX_CYC + 1);

    localparam logic [CNT_W-1:0] C_MULT_LD = CNT_W'(MULT_CYC);
    localparam logic [CNT_W-1:0] C_DIV_LD  = CNT_W'(DIV_CYC);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // A new start can only reach E when the unit is idle (MD users stall
    // while busy), so the load never overwrites a live count.
    always_comb begin
        cnt_d = cnt_q;
        case (md_start_i)
            MD_MULT: cnt_d = C_MULT_LD;
            MD_DIV:  cnt_d = C_DIV_LD;
            default: cnt_d = (cnt_q == '0) ? '0 : cnt_q - 1'b1;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign md_busy_o = (cnt_q != '0);

endmodule
`default_nettype wire

// File: rtl/hazard_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : hazard_ctrl
//  Description : D-stage hazard controller. Keeps a private scoreboard of
//                in-flight GPR writes (E/M/W) that mirrors the pipeline
//                registers, compares D-stage TUse against in-flight TNew to
//                raise Stall (freeze F/D, bubble into E) and picks D-stage
//                forwarding sources. Also stalls HI/LO users while the
//                mult/div unit is busy.
//  Ports       : Clk, Reset          - clock, synchronous active-high reset
//                D_Rs, D_Rt          - source registers of the D instruction
//                D_TUseRs, D_TUseRt  - cycles until operand needed (7 never)
//                D_RegWrite          - D instruction writes a GPR
//                D_WriteReg          - destination GPR
//                D_TNew              - cycles from D until result exists
//                D_MDStart           - 00 none, 01 mult, 10 div
//                D_MDUse             - D instruction uses HI/LO or starts MD
//                Stall               - freeze PC/D, bubble into E
//                FwdRsSel, FwdRtSel  - 0 RF, 1 E, 2 M, 3 W
//                MDBusy              - mult/div counter nonzero
//                StallCnt            - stall-cycle counter (HAZARD_STAT_EN)
//  Config      : HAZARD_STAT_EN adds the StallCnt output and counter.
//  Revision    : 1.0 - initial release
// ============================================================================
module hazard_ctrl #(
    parameter int MULT_CYC = 5,
    parameter int DIV_CYC  = 10,
    parameter int TN_W     = hazard_pkg::TN_W
) (
    input  logic            Clk,
    input  logic            Reset,
    input  logic [4:0]      D_Rs,
    input  logic [4:0]      D_Rt,
    input  logic [TN_W-1:0] D_TUseRs,
    input  logic [TN_W-1:0] D_TUseRt,
    input  logic            D_RegWrite,
    input  logic [4:0]      D_WriteReg,
    input  logic [TN_W-1:0] D_TNew,
    input  logic [1:0]      D_MDStart,
    input  logic            D_MDUse,
    output logic            Stall,
    output logic [1:0]      FwdRsSel,
    output logic [1:0]      FwdRtSel,
    output logic            MDBusy
`ifdef HAZARD_STAT_EN
    ,
    output logic [31:0]     StallCnt
`endif
);
    import hazard_pkg::*;

    localparam logic [TN_W-1:0] C_TUSE_NEVER = TN_W'(TUSE_NEVER);

    // Saturating decrement: a produced result stays ready, never wraps.
    function automatic logic [TN_W-1:0] sat_dec(input logic [TN_W-1:0] v);
        return (v == '0) ? v : v - 1'b1;
    endfunction

    // ------------------------------------------------------------------
    // Scoreboard state, index 0 = E (youngest) .. 2 = W
    // ------------------------------------------------------------------
    logic [NSLOT-1:0]           vld_q,  vld_d;
    logic [NSLOT-1:0][4:0]      addr_q, addr_d;
    logic [NSLOT-1:0][TN_W-1:0] tnew_q, tnew_d;
    logic [1:0]                 e_md_q, e_md_d;

    always_comb begin
        vld_d  = '0;
        addr_d = '0;
        tnew_d = '0;
        e_md_d = MD_NONE;

        // A stalled D instruction leaves a bubble in E
        if (!Stall) begin
            vld_d[SLOT_E]  = D_RegWrite && (D_WriteReg != 5'd0);
            addr_d[SLOT_E] = D_WriteReg;
            tnew_d[SLOT_E] = sat_dec(D_TNew);
            e_md_d         = D_MDStart;
        end

        vld_d[SLOT_M]  = vld_q[SLOT_E];
        addr_d[SLOT_M] = addr_q[SLOT_E];
        tnew_d[SLOT_M] = sat_dec(tnew_q[SLOT_E]);

        vld_d[SLOT_W]  = vld_q[SLOT_M];
        addr_d[SLOT_W] = addr_q[SLOT_M];
        tnew_d[SLOT_W] = sat_dec(tnew_q[SLOT_M]);
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            vld_q  <= '0;
            addr_q <= '0;
            tnew_q <= '0;
            e_md_q <= MD_NONE;
        end else begin
            vld_q  <= vld_d;
            addr_q <= addr_d;
            tnew_q <= tnew_d;
            e_md_q <= e_md_d;
        end
    end

    // ------------------------------------------------------------------
    // Per-slot match and readiness
    // ------------------------------------------------------------------
    logic [NSLOT-1:0] w_rs_hit;
    logic [NSLOT-1:0] w_rt_hit;
    logic [NSLOT-1:0] w_rdy;

    for (genvar g = 0; g < NSLOT; g++) begin : g_slot
        assign w_rs_hit[g] = vld_q[g] && (addr_q[g] == D_Rs) && (D_Rs != 5'd0);
        assign w_rt_hit[g] = vld_q[g] && (addr_q[g] == D_Rt) && (D_Rt != 5'd0);
        assign w_rdy[g]    = (tnew_q[g] == '0);
    end

    // ------------------------------------------------------------------
    // Stall: only E and M can still be producing; W results are always
    // available through the same-cycle RF bypass.
    // ------------------------------------------------------------------
    logic w_rs_stall;
    logic w_rt_stall;
    logic w_md_stall;
    logic w_e_md;

    assign w_rs_stall = (D_TUseRs != C_TUSE_NEVER) &&
                        ((w_rs_hit[SLOT_E] && (tnew_q[SLOT_E] > D_TUseRs)) ||
                         (w_rs_hit[SLOT_M] && (tnew_q[SLOT_M] > D_TUseRs)));
    assign w_rt_stall = (D_TUseRt != C_TUSE_NEVER) &&
                        ((w_rt_hit[SLOT_E] && (tnew_q[SLOT_E] > D_TUseRt)) ||
                         (w_rt_hit[SLOT_M] && (tnew_q[SLOT_M] > D_TUseRt)));

    // An MD start sitting in E has not loaded the counter yet, so it must
    // block HI/LO users on its own.
    assign w_e_md     = (e_md_q == MD_MULT) || (e_md_q == MD_DIV);
    assign w_md_stall = D_MDUse && (MDBusy || w_e_md);

    assign Stall = w_rs_stall || w_rt_stall || w_md_stall;

    // ------------------------------------------------------------------
    // Forward select: the youngest matching slot owns the value; if it is
    // not ready yet, an older ready copy would be stale, so fall back to RF.
    // ------------------------------------------------------------------
    function automatic logic [1:0] fwd_pick(input logic [NSLOT-1:0] hit,
                                            input logic [NSLOT-1:0] rdy);
        if (hit[SLOT_E]) return rdy[SLOT_E] ? FWD_E : FWD_RF;
        if (hit[SLOT_M]) return rdy[SLOT_M] ? FWD_M : FWD_RF;
        if (hit[SLOT_W]) return rdy[SLOT_W] ? FWD_W : FWD_RF;
        return FWD_RF;
    endfunction

    assign FwdRsSel = fwd_pick(w_rs_hit, w_rdy);
    assign FwdRtSel = fwd_pick(w_rt_hit, w_rdy);

    // ------------------------------------------------------------------
    // Mult/div busy tracking
    // ------------------------------------------------------------------
    md_busy_tracker #(
        .MULT_CYC (MULT_CYC),
        .DIV_CYC  (DIV_CYC)
    ) u_md_busy (
        .Clk        (Clk),
        .Reset      (Reset),
        .md_start_i (e_md_q),
        .md_busy_o  (MDBusy)
    );

`ifdef HAZARD_STAT_EN
    logic [31:0] stall_cnt_q;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            stall_cnt_q <= '0;
        end else if (Stall) begin
            stall_cnt_q <= stall_cnt_q + 32'd1;
        end
    end

    assign StallCnt = stall_cnt_q;
`endif

endmodule
`default_nettype wire
